// File: rtl/pipe_rx_hdr_capture.sv
// Captures USB 3.1 header packets (HPST framed) from the 16-bit PIPE RX stream,
// queues them in NUM_SLOTS slots and drains each byte-wide into buf_in with a commit.
// Optional CRC-16 header check is enabled by defining HDR_CRC16_CHECK_EN.
module pipe_rx_hdr_capture #(
  parameter int NUM_SLOTS = 2,
  parameter int ADDR_W    = 9,
  parameter int LEN_W     = 10
) (
  input  logic              phy_pipe_pclk,
  input  logic              reset,
  input  logic [15:0]       phy_pipe_rx_data,
  input  logic [1:0]        phy_pipe_rx_datak,
  input  logic              phy_pipe_rx_valid,
  input  logic              buf_in_ready,
  output logic [ADDR_W-1:0] buf_in_addr,
  output logic [7:0]        buf_in_data,
  output logic              buf_in_wren,
  output logic              buf_in_commit,
  output logic [LEN_W-1:0]  buf_in_commit_len,
  input  logic              buf_in_commit_ack,
  output logic              hdr_rx,
  output logic              err_framing,
  output logic              crc_err,
  output logic [7:0]        hdr_drop_cnt
);

  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [7:0] SHP = 8'hFB;
  localparam logic [7:0] EPF = 8'hF7;
  localparam logic [7:0] SKP = 8'h3C;

  typedef enum logic [1:0] {CAP_HUNT, CAP_HPST1, CAP_DATA, CAP_DONE} cap_state_t;
  typedef enum logic [1:0] {DRN_IDLE, DRN_WRITE, DRN_COMMIT} drn_state_t;

  cap_state_t          r_cap_state;
  drn_state_t          r_drn_state;
  logic [2:0]          r_cnt;
  logic [SLOT_W-1:0]   r_tail;
  logic [SLOT_W-1:0]   r_head;
  logic [NUM_SLOTS-1:0] r_full;
  logic [7:0]          r_cap [16];
  logic [7:0]          r_mem [NUM_SLOTS*16];
  logic [ADDR_W-1:0]   r_base;
  logic [4:0]          r_idx;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_data;
  logic                r_wren;
  logic                r_commit;
  logic [LEN_W-1:0]    r_len;
  logic                r_hdr_rx;
  logic                r_err_framing;
  logic [7:0]          r_drop;

  logic w_skp;
  logic w_word;
  logic w_is_hp;
  logic w_is_ep;
  logic w_data_word;
  logic w_release;
  logic w_slot_free;
  logic w_crc_ok;
  logic w_fill;

  function automatic logic [SLOT_W-1:0] slot_next(input logic [SLOT_W-1:0] s);
    return (s == SLOT_W'(NUM_SLOTS - 1)) ? '0 : s + 1'b1;
  endfunction

  assign w_skp       = phy_pipe_rx_valid && (phy_pipe_rx_datak == 2'b11) &&
                       (phy_pipe_rx_data == {SKP, SKP});
  assign w_word      = phy_pipe_rx_valid && !w_skp;
  assign w_is_hp     = (phy_pipe_rx_datak == 2'b11) && (phy_pipe_rx_data == {SHP, SHP});
  assign w_is_ep     = (phy_pipe_rx_datak == 2'b11) && (phy_pipe_rx_data == {EPF, SHP});
  assign w_data_word = (r_cap_state == CAP_DATA) && w_word && (phy_pipe_rx_datak == 2'b00);
  assign w_release   = (r_drn_state == DRN_COMMIT) && buf_in_commit_ack;
  // A slot released by the drain in the DONE cycle can be refilled at once.
  assign w_slot_free = !r_full[r_tail] || (w_release && (r_head == r_tail));
  assign w_fill      = (r_cap_state == CAP_DONE) && w_crc_ok && w_slot_free;

`ifdef HDR_CRC16_CHECK_EN
  logic [15:0] r_crc;
  logic        r_crc_err;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc;
    for (int unsigned k = 0; k < 8; k++) begin
      if (c[15] ^ b[k]) c = {c[14:0], 1'b0} ^ 16'h100B;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  always_ff @(posedge phy_pipe_pclk or posedge reset) begin
    if (reset) begin
      r_crc     <= 16'hFFFF;
      r_crc_err <= 1'b0;
    end else begin
      r_crc_err <= (r_cap_state == CAP_DONE) && !w_crc_ok;
      if (r_cap_state == CAP_HPST1 && w_word && w_is_ep)
        r_crc <= 16'hFFFF;
      else if (w_data_word && (r_cnt < 3'd6))
        r_crc <= crc16_byte(crc16_byte(r_crc, phy_pipe_rx_data[7:0]), phy_pipe_rx_data[15:8]);
    end
  end

  assign w_crc_ok = ((~r_crc) == {r_cap[13], r_cap[12]});
  assign crc_err  = r_crc_err;
`else
  assign w_crc_ok = 1'b1;
  assign crc_err  = 1'b0;
`endif

  always_ff @(posedge phy_pipe_pclk or posedge reset) begin
    if (reset) begin
      r_cap_state   <= CAP_HUNT;
      r_cnt         <= '0;
      r_tail        <= '0;
      r_hdr_rx      <= 1'b0;
      r_err_framing <= 1'b0;
      r_drop        <= '0;
    end else begin
      r_hdr_rx      <= 1'b0;
      r_err_framing <= 1'b0;
      case (r_cap_state)
        CAP_HUNT: begin
          if (w_word && w_is_hp) r_cap_state <= CAP_HPST1;
        end
        CAP_HPST1: begin
          if (w_word) begin
            if (w_is_ep) begin
              r_cap_state <= CAP_DATA;
              r_cnt       <= '0;
            end else if (!w_is_hp) begin
              r_cap_state <= CAP_HUNT;
            end
          end
        end
        CAP_DATA: begin
          if (w_word) begin
            if (phy_pipe_rx_datak == 2'b00) begin
              r_cnt <= r_cnt + 1'b1;
              if (r_cnt == 3'd7) r_cap_state <= CAP_DONE;
            end else begin
              r_cap_state   <= CAP_HUNT;
              r_err_framing <= 1'b1;
            end
          end
        end
        CAP_DONE: begin
          r_cap_state <= CAP_HUNT;
          if (w_fill) begin
            r_hdr_rx <= 1'b1;
            r_tail   <= slot_next(r_tail);
          end else if (w_crc_ok && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 1'b1;
          end
        end
        default: r_cap_state <= CAP_HUNT;
      endcase
    end
  end

  // Staging buffer keeps the in-flight packet away from slots still being drained.
  always_ff @(posedge phy_pipe_pclk) begin
    if (w_data_word) begin
      r_cap[{r_cnt, 1'b0}] <= phy_pipe_rx_data[7:0];
      r_cap[{r_cnt, 1'b1}] <= phy_pipe_rx_data[15:8];
    end
  end

  always_ff @(posedge phy_pipe_pclk) begin
    if (w_fill) begin
      for (int unsigned b = 0; b < 16; b++) r_mem[{r_tail, 4'(b)}] <= r_cap[b];
    end
  end

  always_ff @(posedge phy_pipe_pclk or posedge reset) begin
    if (reset) begin
      r_full <= '0;
    end else begin
      for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
        if (w_fill && (r_tail == SLOT_W'(s)))
          r_full[s] <= 1'b1;
        else if (w_release && (r_head == SLOT_W'(s)))
          r_full[s] <= 1'b0;
      end
    end
  end

  always_ff @(posedge phy_pipe_pclk or posedge reset) begin
    if (reset) begin
      r_drn_state <= DRN_IDLE;
      r_head      <= '0;
      r_base      <= '0;
      r_idx       <= '0;
      r_wren      <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_commit    <= 1'b0;
      r_len       <= '0;
    end else begin
      case (r_drn_state)
        DRN_IDLE: begin
          if (r_full[r_head] && buf_in_ready) begin
            r_drn_state <= DRN_WRITE;
            r_wren      <= 1'b1;
            r_addr      <= r_base;
            r_data      <= r_mem[{r_head, 4'd0}];
            r_idx       <= 5'd1;
          end
        end
        DRN_WRITE: begin
          if (r_idx[4]) begin
            r_wren      <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_commit    <= 1'b1;
            r_len       <= LEN_W'(16);
            r_drn_state <= DRN_COMMIT;
          end else begin
            r_addr <= r_base + ADDR_W'(r_idx);
            r_data <= r_mem[{r_head, r_idx[3:0]}];
            r_idx  <= r_idx + 1'b1;
          end
        end
        DRN_COMMIT: begin
          if (buf_in_commit_ack) begin
            r_commit    <= 1'b0;
            r_len       <= '0;
            r_base      <= r_base + ADDR_W'(16);
            r_head      <= slot_next(r_head);
            r_drn_state <= DRN_IDLE;
          end
        end
        default: r_drn_state <= DRN_IDLE;
      endcase
    end
  end

  assign buf_in_addr       = r_addr;
  assign buf_in_data       = r_data;
  assign buf_in_wren       = r_wren;
  assign buf_in_commit     = r_commit;
  assign buf_in_commit_len = r_len;
  assign hdr_rx            = r_hdr_rx;
  assign err_framing       = r_err_framing;
  assign hdr_drop_cnt      = r_drop;

endmodule

// File: doc/pipe_rx_hdr_capture.md
Name: pipe_rx_hdr_capture

Overview:
- Sits directly downstream of the PHY PIPE receive interface and upstream of the buf_in endpoint buffer.
- Watches the 16-bit PIPE RX symbol stream and detects USB 3.1 Header Packet framing (HPST).
- Captures the 16-byte header packet: 12-byte header, CRC-16 and link control word.
- Drains the packet byte-wide into buf_in and commits it with a length handshake. Up to NUM_SLOTS packets are queued so capture and drain overlap.

Parameters:
NUM_SLOTS, 2, header packet holding slots (power of two, 1..4)
ADDR_W, 9, width of buf_in_addr
LEN_W, 10, width of buf_in_commit_len

Ports:
phy_pipe_pclk  input  1  PIPE receive clock; sole clock
reset  input  1  asynchronous, active-high reset
phy_pipe_rx_data  input  16  RX symbols; byte [7:0] is first in time
phy_pipe_rx_datak  input  2  K flag per byte, bit0 goes with [7:0]
phy_pipe_rx_valid  input  1  word qualifier; low = word ignored (stall, not abort)
buf_in_ready  input  1  buffer can accept a packet
buf_in_addr  output  ADDR_W  byte write address
buf_in_data  output  8  byte write data
buf_in_wren  output  1  byte write strobe
buf_in_commit  output  1  packet commit request
buf_in_commit_len  output  LEN_W  committed length (always 16)
buf_in_commit_ack  input  1  commit accepted
hdr_rx  output  1  one-cycle pulse when a packet is captured into a slot
err_framing  output  1  one-cycle pulse on framing abort
crc_err  output  1  one-cycle pulse on CRC-16 mismatch (feature only)
hdr_drop_cnt  output  8  saturating count of packets dropped because all slots were full

Behaviour:
- Reset (async, active-high): all outputs 0, slots empty, write base 0, capture FSM in HUNT.
- Symbol constants: SHP=8'hFB (K), EPF=8'hF7 (K), SKP=8'h3C (K).
- Pre-filter: a valid word with datak=2'b11 and both bytes SKP is discarded in every state and never advances the FSM.
- Capture FSM:
  - HUNT: word {SHP,SHP} with datak 11 -> HPST1; all other words stay in HUNT.
  - HPST1: {EPF(high),SHP(low)} with datak 11 -> CAP with byte count 0. A repeated {SHP,SHP} stays in HPST1. Anything else -> HUNT, no error.
  - CAP: each valid word with datak 00 stores 2 bytes into the fill slot. On the 8th word -> DONE. Any word with a nonzero datak that is not SKP -> HUNT and err_framing pulse; partial slot discarded.
  - DONE (1 cycle): if a free slot exists, mark it full and pulse hdr_rx. Otherwise increment hdr_drop_cnt (saturates at 255) and discard. Always -> HUNT. DONE ignores the input word of that cycle; back-to-back HPST needs at least one gap word.
- Slot queue:
  - Circular FIFO of NUM_SLOTS x 16 bytes.
  - Capture writes to the tail slot only; the slot is marked full in DONE.
  - Release at the head (after commit ack) and fill in the same cycle are both honoured.
- Drain FSM:
  - IDLE: head slot full and buf_in_ready=1 -> WRITE.
  - WRITE: 16 consecutive cycles with wren=1, addr=base+i (mod 2^ADDR_W), data=byte i, i=0..15. buf_in_ready is not re-sampled during WRITE.
  - COMMIT: commit=1 and commit_len=16, held until commit_ack is sampled high. On ack: release the slot, base += 16 (wraps), -> IDLE. An ack arriving in the same cycle commit first rises completes immediately.
  - Latency: last data word accepted -> first wren is 2 cycles when a slot is free and ready=1.
- Reset mid-packet drops all slots and any uncommitted write; no commit is issued.

Optional Feature:
- Macro HDR_CRC16_CHECK_EN.
- Defined: a CRC-16 (poly 16'h100B, seed 16'hFFFF, result complemented, per USB 3.1 header CRC) runs over bytes 0..11 during CAP and is compared with bytes 12..13 in DONE.
  - Mismatch: crc_err pulse, packet discarded, no slot consumed, hdr_rx stays 0, hdr_drop_cnt unchanged.
- Undefined: no check; crc_err tied to 0.

Test Plan:
- SKP, {FB,FB}/11, {F7,FB}/11, 8 data words 0x0100..0x0F0E, ready=1 -> hdr_rx once; wren 16 cycles addr 0..15 data 00..0F; commit len 16; after ack base=16.
- Same packet with rx_valid low for 3 cycles mid-CAP and an SKP word inserted -> identical 16 bytes written, no err_framing.
- K word {FD,FD}/11 at capture word 4 -> err_framing pulse, no wren, FSM back in HUNT.
- ready=0, three packets with NUM_SLOTS=2 -> two hdr_rx, hdr_drop_cnt=1; ready=1 -> two commits at base 0 and 16.
- 33 packets drained -> 33rd writes addr 0..15 (wrap at 512); commit_ack delayed 5 cycles -> commit held steady.
- HDR_CRC16_CHECK_EN, header with corrupted CRC byte 12 -> crc_err pulse, no wren; valid CRC -> normal commit.
